// File: rtl/apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : apb_slave_mem
// Purpose  : APB slave that fronts a DEPTH x DATA_W memory. It inserts
//            WAIT_STATES wait cycles per transfer, flags accesses to
//            addresses >= DEPTH with PSLVERR, and reports master protocol
//            errors on protocol_violation.
// Ports    : PCLK               - clock, rising edge
//            PRESET             - synchronous active-high reset
//            PSEL/PENABLE       - APB select / access-phase strobe
//            PADDR/PWRITE/PWDATA- APB address, direction, write data
//            PRDATA             - read data (registered at setup)
//            PREADY             - transfer completion (combinational)
//            PSLVERR            - transfer error, only with PREADY
//            protocol_violation - one-cycle registered pulse per error
// Revision : 1.0 - initial release
// ============================================================================
module apb_slave_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              protocol_violation
);

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is still representable.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] lat_addr;
    logic              lat_write;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        wait_cnt;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              setup;
    logic              in_access;
    logic              ready;
    logic              lat_oor;
    logic              paddr_oor;
    logic              mismatch;
    logic              err;
    logic              viol_next;

    assign setup     = PSEL && !PENABLE;
    assign in_access = (state == ACCESS);
    assign ready     = in_access && (wait_cnt == 4'd0) && PSEL && PENABLE;
    assign lat_oor   = ({1'b0, lat_addr} >= DEPTH_EXT);
    assign paddr_oor = ({1'b0, PADDR} >= DEPTH_EXT);

    // The master must hold address/control (and write data) stable for the
    // whole transfer; any change seen in the completing cycle is an error.
    assign mismatch  = (PADDR != lat_addr) || (PWRITE != lat_write) ||
                       (lat_write && (PWDATA != lat_wdata));
    assign err       = ready && (lat_oor || mismatch);

    // Violations: enable without a setup, select dropped mid-transfer, or
    // unstable bus at completion.
    assign viol_next = ((state == IDLE) && PSEL && PENABLE) ||
                       (in_access && !PSEL) ||
                       (ready && mismatch);

    assign PREADY  = ready;
    assign PSLVERR = err;
    // An erroring read must present zero even though the data was
    // registered at setup.
    assign PRDATA  = err ? '0 : rdata_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (setup) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL || ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath, wait counter, memory and violation pulse
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            lat_addr           <= '0;
            lat_write          <= 1'b0;
            lat_wdata          <= '0;
            wait_cnt           <= 4'd0;
            rdata_q            <= '0;
            protocol_violation <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            protocol_violation <= viol_next;

            if ((state == IDLE) && setup) begin
                lat_addr  <= PADDR;
                lat_write <= PWRITE;
                lat_wdata <= PWDATA;
                wait_cnt  <= WAIT_INIT;
                // Reading at setup lets a read right after a write see the
                // data committed on the previous completing edge.
                rdata_q   <= paddr_oor ? '0 : mem[PADDR[IDX_W-1:0]];
            end else if (in_access) begin
                if (PSEL && PENABLE && (wait_cnt != 4'd0)) begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
                if (err) begin
                    rdata_q <= '0;
                end
            end

            if (ready && lat_write && !err) begin
                mem[lat_addr[IDX_W-1:0]] <= lat_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_slave_mem
// Purpose  : Self-checking bench for apb_slave_mem. Two instances share the
//            bus except for PSEL: dut_a uses WAIT_STATES=1, dut_b uses
//            WAIT_STATES=0. Expected values come from table constants and
//            from a plain array model of each memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_slave_mem;

    localparam int DEPTH = 128;
    localparam int WS_A  = 1;
    localparam int WS_B  = 0;

    logic       PCLK;
    logic       PRESET;
    logic       psel_a;
    logic       psel_b;
    logic       PENABLE;
    logic [7:0] PADDR;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] rdata_a, rdata_b;
    logic       ready_a, ready_b;
    logic       slverr_a, slverr_b;
    logic       pv_a, pv_b;

    int vectors    = 0;
    int miscompares = 0;
    int pv_cnt_a   = 0;
    int pv_cnt_b   = 0;

    logic [7:0] model_a [256];
    logic [7:0] model_b [256];

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t tbl [8];

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_STATES(WS_A)) dut_a (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(rdata_a), .PREADY(ready_a), .PSLVERR(slverr_a),
        .protocol_violation(pv_a)
    );

    apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_STATES(WS_B)) dut_b (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(rdata_b), .PREADY(ready_b), .PSLVERR(slverr_b),
        .protocol_violation(pv_b)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(negedge PCLK) begin
        if (pv_a) pv_cnt_a++;
        if (pv_b) pv_cnt_b++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle();
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        PENABLE = 1'b0;
    endtask

    task automatic clear_models();
        for (int i = 0; i < 256; i++) begin
            model_a[i] = 8'h00;
            model_b[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        idle();
        tick();
        tick();
        PRESET = 1'b0;
        clear_models();
    endtask

    // One complete transfer: setup cycle, then access cycles until PREADY.
    // Leaves the bus selected so a following call is truly back-to-back.
    task automatic xfer(input bit which, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, output logic [7:0] rd,
                        output logic err, output int nacc);
        bit done;
        psel_a  = !which;
        psel_b  = which;
        PENABLE = 1'b0;
        PADDR   = addr;
        PWRITE  = wr;
        PWDATA  = wd;
        tick();
        PENABLE = 1'b1;
        nacc = 0;
        rd   = 8'h00;
        err  = 1'b0;
        done = 1'b0;
        while (!done && nacc < 20) begin
            @(negedge PCLK);
            nacc++;
            if (which ? ready_b : ready_a) begin
                rd   = which ? rdata_b : rdata_a;
                err  = which ? slverr_b : slverr_a;
                done = 1'b1;
            end else begin
                chk("slverr_without_ready", which ? slverr_b : slverr_a, 0);
            end
            tick();
        end
        chk("ready_timeout", done, 1);
    endtask

    // Transfer checked against the array model of the selected instance.
    task automatic do_check(input string tag, input bit which, input logic wr,
                            input logic [7:0] addr, input logic [7:0] wd);
        logic [7:0] rd;
        logic       err;
        int         nacc;
        logic       exp_err;
        logic [7:0] exp_rd;
        exp_err = (int'(addr) >= DEPTH);
        exp_rd  = exp_err ? 8'h00 : (which ? model_b[addr] : model_a[addr]);
        xfer(which, wr, addr, wd, rd, err, nacc);
        chk({tag, "_latency"}, nacc, which ? WS_B + 1 : WS_A + 1);
        chk({tag, "_pslverr"}, err, exp_err);
        if (!wr) chk({tag, "_prdata"}, rd, exp_rd);
        if (wr && !exp_err) begin
            if (which) model_b[addr] = wd;
            else       model_a[addr] = wd;
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic       err;
        int         nacc;
        int         pa0, pb0;
        logic       w;
        logic [7:0] a, d;
        bit         sel;

        PRESET = 1'b1;
        idle();
        PADDR  = 8'h00;
        PWRITE = 1'b0;
        PWDATA = 8'h00;

        tbl[0] = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
        tbl[2] = '{1'b1, 8'h80, 8'h55, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0};
        tbl[4] = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1};
        tbl[5] = '{1'b1, 8'h7F, 8'h12, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 8'h7F, 8'h00, 8'h12, 1'b0};
        tbl[7] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1};

        // ---------------- reset state ----------------
        do_reset();
        @(negedge PCLK);
        chk("rst_pready_a", ready_a, 0);
        chk("rst_pslverr_a", slverr_a, 0);
        chk("rst_pv_a", pv_a, 0);
        chk("rst_prdata_a", rdata_a, 0);
        chk("rst_pready_b", ready_b, 0);
        chk("rst_prdata_b", rdata_b, 0);
        tick();

        // ---------------- table vectors on dut_a ----------------
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, tbl[i].wr, tbl[i].addr, tbl[i].wd, rd, err, nacc);
            chk($sformatf("tbl%0d_latency", i), nacc, WS_A + 1);
            chk($sformatf("tbl%0d_pslverr", i), err, tbl[i].exp_err);
            if (!tbl[i].wr) chk($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp_rd);
            if (tbl[i].wr && !tbl[i].exp_err) model_a[tbl[i].addr] = tbl[i].wd;
        end
        idle();
        tick();

        // ---------------- zero-wait back-to-back on dut_b ----------------
        do_check("b2b_wr", 1'b1, 1'b1, 8'h7F, 8'h3C);
        do_check("b2b_rd", 1'b1, 1'b0, 8'h7F, 8'h00);
        chk("b2b_rd_value", model_b[8'h7F], 8'h3C);
        idle();
        tick();

        // ---------------- unstable address during a write ----------------
        do_reset();
        psel_a = 1'b1; PENABLE = 1'b0; PADDR = 8'h20; PWRITE = 1'b1; PWDATA = 8'h77;
        tick();
        PENABLE = 1'b1;
        PADDR   = 8'h21;
        @(negedge PCLK);
        chk("mm_wait_pready", ready_a, 0);
        chk("mm_wait_pslverr", slverr_a, 0);
        tick();
        @(negedge PCLK);
        chk("mm_done_pready", ready_a, 1);
        chk("mm_done_pslverr", slverr_a, 1);
        chk("mm_done_prdata", rdata_a, 0);
        tick();
        idle();
        @(negedge PCLK);
        chk("mm_pv_pulse", pv_a, 1);
        tick();
        @(negedge PCLK);
        chk("mm_pv_end", pv_a, 0);
        tick();
        do_check("mm_rd20", 1'b0, 1'b0, 8'h20, 8'h00);
        do_check("mm_rd21", 1'b0, 1'b0, 8'h21, 8'h00);
        idle();
        tick();

        // ---------------- enable without setup ----------------
        psel_a = 1'b1; PENABLE = 1'b1; PADDR = 8'h10; PWRITE = 1'b0;
        @(negedge PCLK);
        chk("nosetup_pready", ready_a, 0);
        tick();
        idle();
        @(negedge PCLK);
        chk("nosetup_pv_pulse", pv_a, 1);
        chk("nosetup_pready_after", ready_a, 0);
        tick();
        @(negedge PCLK);
        chk("nosetup_pv_end", pv_a, 0);
        tick();
        do_check("nosetup_recover", 1'b0, 1'b1, 8'h11, 8'h42);
        idle();
        tick();

        // ---------------- select dropped mid-wait ----------------
        psel_a = 1'b1; PENABLE = 1'b0; PADDR = 8'h30; PWRITE = 1'b1; PWDATA = 8'h99;
        tick();
        idle();
        @(negedge PCLK);
        chk("abort_pready", ready_a, 0);
        tick();
        @(negedge PCLK);
        chk("abort_pv_pulse", pv_a, 1);
        chk("abort_pready_after", ready_a, 0);
        tick();
        @(negedge PCLK);
        chk("abort_pv_end", pv_a, 0);
        tick();
        do_check("abort_rd30", 1'b0, 1'b0, 8'h30, 8'h00);
        idle();
        tick();

        // ---------------- reset on the completing edge of a write ----------------
        do_check("rst_prewr", 1'b0, 1'b1, 8'h05, 8'h5A);
        psel_a = 1'b1; PENABLE = 1'b0; PADDR = 8'h05; PWRITE = 1'b1; PWDATA = 8'hEE;
        tick();
        PENABLE = 1'b1;
        tick();
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("rst_mid_prdata_loaded", rdata_a, 8'h5A);
        tick();
        PRESET = 1'b0;
        idle();
        clear_models();
        @(negedge PCLK);
        chk("rst_mid_pready", ready_a, 0);
        chk("rst_mid_pslverr", slverr_a, 0);
        chk("rst_mid_prdata", rdata_a, 0);
        tick();
        do_check("rst_mid_rd05", 1'b0, 1'b0, 8'h05, 8'h00);
        idle();
        tick();

        // ---------------- randomized transfers vs. model ----------------
        pa0 = pv_cnt_a;
        pb0 = pv_cnt_b;
        for (int i = 0; i < 240; i++) begin
            sel = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       a = 8'($urandom_range(128, 255));
                1:       a = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h80;
                default: a = 8'($urandom_range(0, 15));
            endcase
            d = 8'($urandom_range(0, 255));
            do_check($sformatf("rnd%0d", i), sel, w, a, d);
            if ($urandom_range(0, 2) == 0) begin
                idle();
                tick();
            end
        end
        idle();
        tick();
        tick();
        chk("rnd_no_pv_a", pv_cnt_a - pa0, 0);
        chk("rnd_no_pv_b", pv_cnt_b - pb0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB slave holding a DEPTH x DATA_W register/memory array.
- Sits directly downstream of the APB master bridge. One instance hangs off each peripheral select (PSEL1 or PSEL2); the instance receives PADDR[ADDR_W-1:0], and PADDR[8] has already been decoded into the select.
- Returns PRDATA/PREADY/PSLVERR to the bridge.
- Inserts programmable wait states, flags out-of-range accesses and detects APB protocol violations by the master.

Parameters:
- ADDR_W, 8, address bits seen by the slave.
- DATA_W, 8, data width.
- DEPTH, 128, implemented locations. Addresses >= DEPTH are out of range.
- WAIT_STATES, 1, access-phase cycles with PREADY=0 before completion (0..15).

Ports:
- PCLK, input, 1, clock; all state updates on the rising edge.
- PRESET, input, 1, reset: synchronous, active-high.
- PSEL, input, 1, slave select from the bridge.
- PENABLE, input, 1, access phase indicator.
- PADDR, input, ADDR_W, byte address.
- PWRITE, input, 1: 1 = write, 0 = read.
- PWDATA, input, DATA_W, write data.
- PRDATA, output, DATA_W, read data; valid when PREADY=1 and PWRITE was 0.
- PREADY, output, 1, transfer completion.
- PSLVERR, output, 1, transfer error; valid only with PREADY.
- protocol_violation, output, 1, one-cycle pulse on a master protocol error.

Behaviour:
- Reset (PRESET=1 at the clock edge; highest priority):
  - state=IDLE, wait counter=0, PRDATA=0, latched address/control/data=0, all memory locations=0.
  - PREADY=0, PSLVERR=0, protocol_violation=0.
  - A write completing on the same edge is discarded.
- State machine, two states: IDLE and ACCESS.
- IDLE:
  - Setup cycle (PSEL=1, PENABLE=0): latch PADDR/PWRITE/PWDATA, load counter=WAIT_STATES, go to ACCESS.
  - On the same edge, load PRDATA <= mem[PADDR] if in range, else 0.
  - PSEL=1, PENABLE=1 in IDLE (no prior setup): pulse protocol_violation next cycle, stay IDLE, no PREADY.
  - PSEL=0: stay IDLE.
- ACCESS:
  - PREADY is combinational: PREADY = (state==ACCESS && counter==0 && PSEL && PENABLE).
  - Counter decrements each ACCESS cycle with PSEL&&PENABLE while non-zero.
  - Completion happens in the cycle PREADY=1; return to IDLE on that edge.
  - Write completion with no error: mem[latched addr] <= latched data on the completing edge.
  - Read completion: PRDATA holds the value loaded at setup.
  - PSEL=1, PENABLE=0 while in ACCESS: ignore; hold counter, PREADY=0.
  - PSEL dropped in ACCESS: abort to IDLE, no write, pulse protocol_violation.
- Latency: PREADY rises in access cycle WAIT_STATES+1. Total transfer = WAIT_STATES+2 cycles (setup + access).
- Back-to-back transfers: the bridge goes ENABLE->SETUP directly. The setup cycle following completion is seen in IDLE, so no dead cycle is inserted. A read immediately after a write to the same address returns the new data.
- PSLVERR = PREADY && (latched addr >= DEPTH || mismatch).
  - mismatch: current PADDR/PWRITE (and PWDATA for writes) differ from the latched values during the completing cycle.
  - An erroring write does not modify memory.
  - An erroring read returns PRDATA=0.
  - A mismatch also pulses protocol_violation.
- PSLVERR is 0 whenever PREADY=0.
- protocol_violation is registered: exactly one cycle per event, never on a clean transfer.
- Address is not wrapped: out-of-range addresses error and are never aliased.

Test Plan:
1. Reset, then write 0xA5 to 0x10, then read 0x10 (WAIT_STATES=1) -> the read's PREADY is low in the first access cycle and high in the second; PRDATA=0xA5; PSLVERR=0 throughout.
2. WAIT_STATES=0: back-to-back write 0x3C to 0x7F, then read 0x7F with no idle cycle -> each transfer takes 2 cycles; PRDATA=0x3C.
3. Write 0x55 to 0x80 (DEPTH=128) -> PREADY=1 with PSLVERR=1. A following read of 0x00 returns 0x00; no aliasing.
4. Change PADDR from 0x20 to 0x21 during the access phase of a write of 0x77 -> PSLVERR=1 at completion, protocol_violation pulses, mem[0x20] and mem[0x21] unchanged (read back 0x00).
5. PENABLE=1 with PSEL=1 and no setup cycle; separately, PSEL dropped mid-wait -> PREADY stays 0, protocol_violation is high for exactly one cycle per event, FSM returns to IDLE.
6. Assert PRESET during the access phase of a write of 0xEE to 0x05 -> the next cycle shows PREADY=0, PSLVERR=0, PRDATA=0; a subsequent read of 0x05 returns 0x00.
